// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: operation codes and the
// controller state type used by the top level.
package alu_pkg;

    // Operation codes presented on the op input
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    // Controller states: waiting, shifting bits through the slice, reporting
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

    // Arithmetic operations are the ones that use the carry chain
    function automatic logic is_arith(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: optional per-bit inversion of both operands, then
// AND / OR / full-adder sum / pass-through of the "less" input. The carry
// output is always the full-adder carry of the inverted operands so the
// caller can keep the chain running regardless of the selected operation.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic [1:0] i_op,
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_a_invert,
    input  logic       i_b_invert,
    input  logic       i_carry,
    input  logic       i_less,
    output logic       o_result,
    output logic       o_sum,
    output logic       o_carry
);

    logic w_a;
    logic w_b;

    assign w_a     = i_a ^ i_a_invert;
    assign w_b     = i_b ^ i_b_invert;
    assign o_sum   = w_a ^ w_b ^ i_carry;
    assign o_carry = (w_a & w_b) | (w_a & i_carry) | (w_b & i_carry);

    // Select the slice output for the requested operation
    always_comb begin
        o_result = 1'b0;
        case (i_op)
            OP_AND:  o_result = w_a & w_b;
            OP_OR:   o_result = w_a | w_b;
            OP_ADD:  o_result = o_sum;
            OP_SLT:  o_result = i_less;
            default: o_result = 1'b0;
        endcase
    end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: processes one operand bit per clock, LSB first, through a
// single shared slice. Operands are latched and shifted right so the slice
// always sees bit 0; the partial result is shifted into a shadow register and
// only copied to the visible outputs on the last bit, so result and flags
// stay stable for the whole run.
module bit_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             a_invert,
    input  logic             b_invert,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int             CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic             r_a_invert;
    logic             r_b_invert;
    logic             r_carry;
    logic [CW-1:0]    r_idx;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_result;
    logic             r_carry_out;
    logic             r_overflow;
    logic             r_zero;

    logic             w_busy;
    logic             w_done;
    logic             w_accept;
    logic             w_last;
    logic             w_slice_result;
    logic             w_slice_sum;
    logic             w_slice_carry;
    logic             w_overflow;
    logic             w_slt_bit;
    logic [WIDTH-1:0] w_final;

    alu_bit_slice u_slice (
        .i_op       (r_op),
        .i_a        (r_a[0]),
        .i_b        (r_b[0]),
        .i_a_invert (r_a_invert),
        .i_b_invert (r_b_invert),
        .i_carry    (r_carry),
        .i_less     (1'b0),
        .o_result   (w_slice_result),
        .o_sum      (w_slice_sum),
        .o_carry    (w_slice_carry)
    );

    // A new operation can start whenever the block is not running, which
    // includes the reporting cycle so operations can run back to back.
    assign w_accept   = start && ((r_state == IDLE) || (r_state == FIN));
    assign w_last     = (r_state == RUN) && (r_idx == LAST_IDX);

    // On the MSB cycle r_carry is the carry into the MSB
    assign w_overflow = r_carry ^ w_slice_carry;
    assign w_slt_bit  = w_slice_sum ^ w_overflow;
    assign w_final    = (r_op == OP_SLT) ? {{(WIDTH-1){1'b0}}, w_slt_bit}
                                         : {w_slice_result, r_shadow[WIDTH-1:1]};

    // Controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and status decode
    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next = FIN;
                end
            end
            FIN: begin
                w_done = 1'b1;
                w_next = start ? RUN : IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operand capture, bit-serial datapath and result publication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= OP_AND;
            r_a_invert  <= 1'b0;
            r_b_invert  <= 1'b0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_shadow    <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b1;
        end else if (w_accept) begin
            r_a        <= a;
            r_b        <= b;
            r_op       <= op;
            r_a_invert <= a_invert;
            r_b_invert <= b_invert;
            r_carry    <= carry_in;
            r_idx      <= '0;
        end else if (r_state == RUN) begin
            r_a      <= {1'b0, r_a[WIDTH-1:1]};
            r_b      <= {1'b0, r_b[WIDTH-1:1]};
            r_carry  <= w_slice_carry;
            r_idx    <= r_idx + CW'(1);
            r_shadow <= {w_slice_result, r_shadow[WIDTH-1:1]};
            if (w_last) begin
                r_result    <= w_final;
                r_carry_out <= is_arith(r_op) ? w_slice_carry : 1'b0;
                r_overflow  <= is_arith(r_op) ? w_overflow : 1'b0;
                r_zero      <= (w_final == '0);
            end
        end
    end

    assign busy      = w_busy;
    assign done      = w_done;
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

endmodule

// File: tb/tb_bit_serial_alu.sv
// Self-checking bench for bit_serial_alu (WIDTH=8). Expected outcomes are
// pushed to a scoreboard queue when an operation is issued and popped when
// the DUT pulses done.
module tb_bit_serial_alu;
    import alu_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        logic         zer;
    } exp_t;

    typedef struct packed {
        logic [1:0]   op;
        logic         ai;
        logic         bi;
        logic         ci;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        exp_t         e;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic         a_invert = 1'b0;
    logic         b_invert = 1'b0;
    logic         carry_in = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    int           n_checks = 0;
    int           n_fail = 0;
    exp_t         sb[$];
    logic [W-1:0] last_res = '0;

    bit_serial_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a_invert  (a_invert),
        .b_invert  (b_invert),
        .carry_in  (carry_in),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Reference model built from whole-word arithmetic
    function automatic exp_t model(input logic [1:0] o, input logic ai, input logic bi,
                                   input logic ci, input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W:0]   s;
        logic         v;
        exp_t         e;
        x = ai ? ~av : av;
        y = bi ? ~bv : bv;
        s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        e = '0;
        case (o)
            OP_AND: e.res = x & y;
            OP_OR:  e.res = x | y;
            OP_ADD: begin e.res = s[W-1:0]; e.cout = s[W]; e.ovf = v; end
            default: begin e.res = {{(W-1){1'b0}}, s[W-1] ^ v}; e.cout = s[W]; e.ovf = v; end
        endcase
        e.zer = (e.res == '0);
        return e;
    endfunction

    // Drive one start request; returns at the negedge of the first RUN cycle
    task automatic drive_op(input bit at_edge, input logic [1:0] o, input logic ai, input logic bi,
                            input logic ci, input logic [W-1:0] av, input logic [W-1:0] bv);
        if (at_edge) @(negedge clk);
        start = 1'b1; op = o; a_invert = ai; b_invert = bi; carry_in = ci; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for done; lat counts cycles since the accepting cycle
    task automatic wait_done(input int lat0, output int lat, output bit timeout);
        lat = lat0;
        timeout = 1'b0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) timeout = 1'b1;
    endtask

    task automatic test_reset();
        exp_t got;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        got = {result, carry_out, overflow, zero};
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_status: busy=%b done=%b, expected busy=0 done=0", busy, done);
        end
        n_checks++;
        if (got !== exp_t'({8'h00, 1'b0, 1'b0, 1'b1})) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: res=%h co=%b ov=%b z=%b, expected res=00 co=0 ov=0 z=1",
                     result, carry_out, overflow, zero);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fixed_vectors();
        vec_t vecs[7];
        exp_t e;
        exp_t got;
        int   lat;
        bit   to;
        vecs[0] = '{op:OP_AND, ai:1'b0, bi:1'b0, ci:1'b0, av:8'hC3, bv:8'h5A, e:'{res:8'h42, cout:1'b0, ovf:1'b0, zer:1'b0}};
        vecs[1] = '{op:OP_ADD, ai:1'b0, bi:1'b0, ci:1'b0, av:8'h7F, bv:8'h01, e:'{res:8'h80, cout:1'b0, ovf:1'b1, zer:1'b0}};
        vecs[2] = '{op:OP_ADD, ai:1'b0, bi:1'b1, ci:1'b1, av:8'h05, bv:8'h05, e:'{res:8'h00, cout:1'b1, ovf:1'b0, zer:1'b1}};
        vecs[3] = '{op:OP_SLT, ai:1'b0, bi:1'b1, ci:1'b1, av:8'h80, bv:8'h01, e:'{res:8'h01, cout:1'b1, ovf:1'b1, zer:1'b0}};
        vecs[4] = '{op:OP_SLT, ai:1'b0, bi:1'b1, ci:1'b1, av:8'h01, bv:8'h80, e:'{res:8'h00, cout:1'b0, ovf:1'b1, zer:1'b1}};
        vecs[5] = '{op:OP_AND, ai:1'b1, bi:1'b1, ci:1'b0, av:8'h0F, bv:8'hF0, e:'{res:8'h00, cout:1'b0, ovf:1'b0, zer:1'b1}};
        vecs[6] = '{op:OP_OR,  ai:1'b1, bi:1'b1, ci:1'b0, av:8'h0F, bv:8'hF0, e:'{res:8'hFF, cout:1'b0, ovf:1'b0, zer:1'b0}};
        for (int i = 0; i < 7; i++) begin
            sb.push_back(vecs[i].e);
            drive_op(1'b1, vecs[i].op, vecs[i].ai, vecs[i].bi, vecs[i].ci, vecs[i].av, vecs[i].bv);
            wait_done(1, lat, to);
            e = sb.pop_front();
            got = {result, carry_out, overflow, zero};
            n_checks++;
            if (to || lat != W + 1) begin
                n_fail++;
                $display("[TB] FAIL vec%0d_latency: done after %0d cycles (timeout=%b), expected %0d", i, lat, to, W + 1);
            end
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("[TB] FAIL vec%0d_result: res=%h co=%b ov=%b z=%b, expected res=%h co=%b ov=%b z=%b",
                         i, result, carry_out, overflow, zero, e.res, e.cout, e.ovf, e.zer);
            end
            last_res = e.res;
        end
    endtask

    task automatic test_random();
        exp_t         e;
        exp_t         got;
        int           lat;
        bit           to;
        logic [1:0]   o;
        logic         ai, bi, ci;
        logic [W-1:0] av, bv;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            ai = 1'($urandom_range(0, 1));
            bi = 1'($urandom_range(0, 1));
            ci = 1'($urandom_range(0, 1));
            av = 8'($urandom_range(0, 255));
            bv = 8'($urandom_range(0, 255));
            sb.push_back(model(o, ai, bi, ci, av, bv));
            drive_op(1'b1, o, ai, bi, ci, av, bv);
            wait_done(1, lat, to);
            e = sb.pop_front();
            got = {result, carry_out, overflow, zero};
            n_checks++;
            if (to || got !== e) begin
                n_fail++;
                $display("[TB] FAIL rand%0d op=%0d ai=%b bi=%b ci=%b a=%h b=%h: res=%h co=%b ov=%b z=%b timeout=%b, expected res=%h co=%b ov=%b z=%b",
                         i, o, ai, bi, ci, av, bv, result, carry_out, overflow, zero, to, e.res, e.cout, e.ovf, e.zer);
            end
            last_res = e.res;
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        exp_t got;
        int   lat;
        bit   to;
        int   extra;
        sb.push_back(model(OP_ADD, 1'b0, 1'b0, 1'b0, 8'h12, 8'h34));
        drive_op(1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, 8'h12, 8'h34);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (result !== last_res) begin
            n_fail++;
            $display("[TB] FAIL hold_during_run: result=%h, expected previous %h", result, last_res);
        end
        start = 1'b1; op = OP_AND; a = 8'hFF; b = 8'hFF;
        @(negedge clk);
        start = 1'b0; a = 8'h00; b = 8'h00;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL busy_in_run: busy=%b, expected 1", busy);
        end
        wait_done(4, lat, to);
        e = sb.pop_front();
        got = {result, carry_out, overflow, zero};
        n_checks++;
        if (to || lat != W + 1 || got !== e) begin
            n_fail++;
            $display("[TB] FAIL ignore_start_result: res=%h co=%b ov=%b z=%b lat=%0d, expected res=%h co=%b ov=%b z=%b lat=%0d",
                     result, carry_out, overflow, zero, lat, e.res, e.cout, e.ovf, e.zer, W + 1);
        end
        last_res = e.res;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy === 1'b1 || done === 1'b1) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("[TB] FAIL start_not_queued: %0d busy/done cycles, expected 0", extra);
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        exp_t got;
        int   lat;
        bit   to;
        int   spurious;
        sb.push_back(model(OP_ADD, 1'b0, 1'b0, 1'b0, 8'h21, 8'h43));
        drive_op(1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, 8'h21, 8'h43);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(sb.pop_front());
        got = {result, carry_out, overflow, zero};
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || got !== exp_t'({8'h00, 1'b0, 1'b0, 1'b1})) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_run: busy=%b done=%b res=%h co=%b ov=%b z=%b, expected busy=0 done=0 res=00 co=0 ov=0 z=1",
                     busy, done, result, carry_out, overflow, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) spurious++;
        end
        n_checks++;
        if (spurious != 0) begin
            n_fail++;
            $display("[TB] FAIL abandoned_op: %0d busy/done cycles after reset, expected 0", spurious);
        end
        sb.push_back(model(OP_OR, 1'b0, 1'b0, 1'b0, 8'h81, 8'h18));
        drive_op(1'b1, OP_OR, 1'b0, 1'b0, 1'b0, 8'h81, 8'h18);
        wait_done(1, lat, to);
        e = sb.pop_front();
        got = {result, carry_out, overflow, zero};
        n_checks++;
        if (to || lat != W + 1 || got !== e) begin
            n_fail++;
            $display("[TB] FAIL after_reset_op: res=%h co=%b ov=%b z=%b lat=%0d, expected res=%h co=%b ov=%b z=%b lat=%0d",
                     result, carry_out, overflow, zero, lat, e.res, e.cout, e.ovf, e.zer, W + 1);
        end
        last_res = e.res;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t got;
        int   lat;
        bit   to;
        sb.push_back(model(OP_ADD, 1'b0, 1'b1, 1'b1, 8'h10, 8'h20));
        drive_op(1'b1, OP_ADD, 1'b0, 1'b1, 1'b1, 8'h10, 8'h20);
        wait_done(1, lat, to);
        e = sb.pop_front();
        got = {result, carry_out, overflow, zero};
        n_checks++;
        if (to || got !== e) begin
            n_fail++;
            $display("[TB] FAIL b2b_first: res=%h co=%b ov=%b z=%b timeout=%b, expected res=%h co=%b ov=%b z=%b",
                     result, carry_out, overflow, zero, to, e.res, e.cout, e.ovf, e.zer);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL busy_in_fin: busy=%b, expected 0", busy);
        end
        sb.push_back(model(OP_SLT, 1'b0, 1'b1, 1'b1, 8'hF0, 8'h05));
        drive_op(1'b0, OP_SLT, 1'b0, 1'b1, 1'b1, 8'hF0, 8'h05);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL b2b_accept: busy=%b, expected 1", busy);
        end
        wait_done(1, lat, to);
        e = sb.pop_front();
        got = {result, carry_out, overflow, zero};
        n_checks++;
        if (to || lat != W + 1 || got !== e) begin
            n_fail++;
            $display("[TB] FAIL b2b_second: res=%h co=%b ov=%b z=%b lat=%0d, expected res=%h co=%b ov=%b z=%b lat=%0d",
                     result, carry_out, overflow, zero, lat, e.res, e.cout, e.ovf, e.zer, W + 1);
        end
        last_res = e.res;
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_fixed_vectors();
        test_random();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound in case the sequence ever stalls
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
